// File: rtl/calc_sequencer_if.sv
// Calculator sequencer bus: key input, number-entry link, ALU handshake and display select.
interface calc_sequencer_if #(
  parameter int unsigned W = 10
);
  logic [4:0]   key_value;
  logic [W-1:0] d_number;
  logic         alu_done;
  logic         alu_err;
  logic [W:0]   alu_result;
  logic         num_clr;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [1:0]   op_code;
  logic         alu_start;
  logic [1:0]   disp_sel;
  logic [W-1:0] disp_value;

  // Sequencer side
  modport master (
    input  key_value, d_number, alu_done, alu_err, alu_result,
    output num_clr, op_a, op_b, op_code, alu_start, disp_sel, disp_value
  );

  // Keypad / entry register / ALU side
  modport slave (
    output key_value, d_number, alu_done, alu_err, alu_result,
    input  num_clr, op_a, op_b, op_code, alu_start, disp_sel, disp_value
  );
endinterface

// File: rtl/calc_sequencer.sv
// calc_sequencer: key-driven control FSM for the four-function calculator.
module calc_sequencer #(
  parameter int unsigned RELEASE_CNT = 100000,
  parameter int unsigned W           = 10,
  parameter int unsigned ALU_TMO     = 255
) (
  input  logic             clk,
  input  logic             rest,
  calc_sequencer_if.master bus
);
  localparam int unsigned RC_W    = $clog2(RELEASE_CNT + 1);
  localparam int unsigned TMO_W   = $clog2(ALU_TMO + 1);
  localparam int unsigned MAX_VAL = 999;
  localparam logic [W:0]  MAX_RES = (W+1)'(MAX_VAL);

  localparam logic [4:0] K_NONE = 5'd17;
  localparam logic [4:0] K_CLR  = 5'd12;
  localparam logic [4:0] K_ADD  = 5'd3;
  localparam logic [4:0] K_SUB  = 5'd7;
  localparam logic [4:0] K_MUL  = 5'd11;
  localparam logic [4:0] K_DIV  = 5'd15;
  localparam logic [4:0] K_EQ   = 5'd14;

  typedef enum logic [2:0] {S_A, S_B, S_EXEC, S_RES, S_ERR} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     op_a_q, op_a_d;
  logic [W-1:0]     op_b_q, op_b_d;
  logic [1:0]       op_code_q, op_code_d;
  logic [W-1:0]     result_q, result_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             num_clr_q, num_clr_d;
  logic             alu_start_q, alu_start_d;
  logic [1:0]       disp_sel_q, disp_sel_d;
  logic [W-1:0]     disp_value_c;

  logic [RC_W-1:0]  rel_cnt;
  logic             armed_c, key_evt_c;
  logic             is_op_c, is_eq_c, is_clr_c, is_digit_c;
  logic [1:0]       op_sel_c;

  // Key qualification: one event per press, re-armed after a long enough release
  assign armed_c   = (rel_cnt == RC_W'(RELEASE_CNT));
  assign key_evt_c = armed_c && (bus.key_value != K_NONE);

  // Release counter: consecutive no-key cycles, saturating at the re-arm threshold
  always_ff @(posedge clk) begin
    if (!rest) begin
      rel_cnt <= '0;
    end else if (bus.key_value != K_NONE) begin
      rel_cnt <= '0;
    end else if (!armed_c) begin
      rel_cnt <= rel_cnt + RC_W'(1);
    end
  end

  // Key classification and operator encoding
  always_comb begin
    is_op_c  = 1'b0;
    op_sel_c = 2'd0;
    case (bus.key_value)
      K_ADD: begin is_op_c = 1'b1; op_sel_c = 2'd0; end
      K_SUB: begin is_op_c = 1'b1; op_sel_c = 2'd1; end
      K_MUL: begin is_op_c = 1'b1; op_sel_c = 2'd2; end
      K_DIV: begin is_op_c = 1'b1; op_sel_c = 2'd3; end
      default: ;
    endcase
  end

  assign is_eq_c    = (bus.key_value == K_EQ);
  assign is_clr_c   = (bus.key_value == K_CLR);
  assign is_digit_c = !is_op_c && !is_eq_c && !is_clr_c && (bus.key_value != K_NONE);

  // Control registers: state, latched operands/result and registered outputs
  always_ff @(posedge clk) begin
    if (!rest) begin
      state_q     <= S_A;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_code_q   <= '0;
      result_q    <= '0;
      tmo_q       <= '0;
      num_clr_q   <= 1'b1;
      alu_start_q <= 1'b0;
      disp_sel_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_code_q   <= op_code_d;
      result_q    <= result_d;
      tmo_q       <= tmo_d;
      num_clr_q   <= num_clr_d;
      alu_start_q <= alu_start_d;
      disp_sel_q  <= disp_sel_d;
    end
  end

  // Next state and next register values; clear key overrides every state
  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_code_d   = op_code_q;
    result_d    = result_q;
    tmo_d       = tmo_q;
    num_clr_d   = 1'b0;
    alu_start_d = 1'b0;

    case (state_q)
      S_A: begin
        if (key_evt_c && is_op_c) begin
          op_a_d    = bus.d_number;
          op_code_d = op_sel_c;
          num_clr_d = 1'b1;
          state_d   = S_B;
        end
      end
      S_B: begin
        if (key_evt_c && is_op_c) begin
          op_code_d = op_sel_c;
        end else if (key_evt_c && is_eq_c) begin
          op_b_d      = bus.d_number;
          tmo_d       = '0;
          alu_start_d = 1'b1;
          state_d     = S_EXEC;
        end
      end
      S_EXEC: begin
        if (bus.alu_done) begin
          if (bus.alu_err || (bus.alu_result > MAX_RES)) begin
            state_d = S_ERR;
          end else begin
            result_d = W'(bus.alu_result);
            state_d  = S_RES;
          end
        end else if (tmo_q == TMO_W'(ALU_TMO - 1)) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_RES: begin
        if (key_evt_c && is_op_c) begin
          op_a_d    = result_q;
          op_code_d = op_sel_c;
          num_clr_d = 1'b1;
          state_d   = S_B;
        end else if (key_evt_c && is_digit_c) begin
          num_clr_d = 1'b1;
          state_d   = S_A;
        end
      end
      S_ERR: ;
      default: state_d = S_A;
    endcase

    if (key_evt_c && is_clr_c) begin
      op_a_d      = '0;
      op_b_d      = '0;
      op_code_d   = '0;
      result_d    = '0;
      num_clr_d   = 1'b1;
      alu_start_d = 1'b0;
      state_d     = S_A;
    end

    case (state_d)
      S_RES:   disp_sel_d = 2'd1;
      S_ERR:   disp_sel_d = 2'd2;
      default: disp_sel_d = 2'd0;
    endcase
  end

  // Display source: live entry, held result, or blank on error
  always_comb begin
    disp_value_c = '0;
    case (disp_sel_q)
      2'd0:    disp_value_c = bus.d_number;
      2'd1:    disp_value_c = result_q;
      default: disp_value_c = '0;
    endcase
  end

  assign bus.num_clr    = num_clr_q;
  assign bus.op_a       = op_a_q;
  assign bus.op_b       = op_b_q;
  assign bus.op_code    = op_code_q;
  assign bus.alu_start  = alu_start_q;
  assign bus.disp_sel   = disp_sel_q;
  assign bus.disp_value = disp_value_c;
endmodule
